bch_t2_decoder: RTL

BCH_T2_DECODER -- requirements
Module: bch_t2_decoder

---
 rtl/bch_t2_decoder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/bch_t2_decoder.sv
// Binary BCH t=2 decoder over GF(2^M): bit-serial syndromes,
// closed-form locator, Chien search, then buffered corrected output.
module bch_t2_decoder #(
  parameter int         M         = 6,
  parameter logic [M:0] PRIM_POLY = 7'b1000011,
  parameter int         N         = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [1:0] out_err_cnt,
  output logic       out_uncorr
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_EDP    = 2'd1;
  localparam logic [1:0] S_CHIEN  = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [M-1:0]  ONE   = M'(1);
  localparam logic [M-1:0]  ALPHA = M'(2);

  function automatic logic [M-1:0] gf_mul(
    input logic [M-1:0] a,
    input logic [M-1:0] b
  );
    logic [M-1:0] r;
    logic [M-1:0] x;
    r = '0;
    x = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) r = r ^ x;
      x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
    end
    return r;
  endfunction

  // a^(2^M-2) = product of a^(2^k), k=1..M-1
  function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
    logic [M-1:0] r;
    logic [M-1:0] sq;
    r  = ONE;
    sq = a;
    for (int k = 1; k < M; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  buf_q, buf_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [M-1:0]  s1_q, s1_d;
  logic [M-1:0]  s3_q, s3_d;
  logic [M-1:0]  a1_q, a1_d;
  logic [M-1:0]  a3_q, a3_d;
  logic [M-1:0]  s2_q, s2_d;
  logic [1:0]    exp_q, exp_d;
  logic [1:0]    roots_q, roots_d;
  logic [1:0]    ec_q, ec_d;
  logic          unc_q, unc_d;

  logic [M-1:0] alpha3;
  logic [M-1:0] lval;
  logic [M-1:0] s2_calc;
  logic         hit;
  logic         last;
  logic [1:0]   roots_n;

  assign alpha3  = gf_mul(ALPHA, gf_mul(ALPHA, ALPHA));
  assign last    = (cnt_q == LAST);
  assign lval    = gf_mul(a1_q, a1_q) ^ gf_mul(s1_q, a1_q) ^ s2_q;
  assign hit     = (lval == '0);
  assign roots_n = roots_q + {1'b0, hit};
  assign s2_calc = (s1_q == '0) ? '0
                 : (gf_mul(s1_q, s1_q) ^ gf_mul(s3_q, gf_inv(s1_q)));

  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_UNLOAD);
  assign out_data    = out_valid & (buf_q[cnt_q] ^ mask_q[cnt_q]);
  assign out_last    = out_valid & last;
  assign out_err_cnt = ec_q;
  assign out_uncorr  = unc_q;

  // next-state: load/syndromes, locator, Chien search, unload
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    mask_d  = mask_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    a1_d    = a1_q;
    a3_d    = a3_q;
    s2_d    = s2_q;
    exp_d   = exp_q;
    roots_d = roots_q;
    ec_d    = ec_q;
    unc_d   = unc_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          buf_d[cnt_q] = in_data;
          if (in_data) begin
            s1_d = s1_q ^ a1_q;
            s3_d = s3_q ^ a3_q;
          end
          a1_d = gf_mul(a1_q, ALPHA);
          a3_d = gf_mul(a3_q, alpha3);
          if (last) begin
            state_d = S_EDP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_EDP: begin
        s2_d = s2_calc;
        // 3 can never match a degree-2 root count
        if (s1_q == '0) exp_d = (s3_q == '0) ? 2'd0 : 2'd3;
        else            exp_d = (s2_calc == '0) ? 2'd1 : 2'd2;
        a1_d    = ONE;
        cnt_d   = '0;
        state_d = S_CHIEN;
      end
      S_CHIEN: begin
        mask_d[cnt_q] = hit;
        roots_d       = roots_n;
        a1_d          = gf_mul(a1_q, ALPHA);
        if (last) begin
          state_d = S_UNLOAD;
          cnt_d   = '0;
          if (roots_n != exp_q) begin
            unc_d  = 1'b1;
            ec_d   = 2'd0;
            mask_d = '0;
          end else begin
            ec_d = roots_n;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (last) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            mask_d  = '0;
            s1_d    = '0;
            s3_d    = '0;
            a1_d    = ONE;
            a3_d    = ONE;
            s2_d    = '0;
            exp_d   = 2'd0;
            roots_d = 2'd0;
            ec_d    = 2'd0;
            unc_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // state registers, synchronous reset aborts any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      buf_q   <= '0;
      mask_q  <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      a1_q    <= ONE;
      a3_q    <= ONE;
      s2_q    <= '0;
      exp_q   <= 2'd0;
      roots_q <= 2'd0;
      ec_q    <= 2'd0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      a1_q    <= a1_d;
      a3_q    <= a3_d;
      s2_q    <= s2_d;
      exp_q   <= exp_d;
      roots_q <= roots_d;
      ec_q    <= ec_d;
      unc_q   <= unc_d;
    end
  end

endmodule
